// File: rtl/tsp_tour_checker.sv
// Walks a 64-city tour one step per cycle. It sums the closed-tour Manhattan length
// and checks that the visiting order is a permutation of 0..63.
module tsp_tour_checker #(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] xs [63:0],
  input  logic [COORD_W-1:0] ys [63:0],
  input  logic [5:0]         path [63:0],
  output logic               busy,
  output logic               done,
  output logic [COORD_W+7:0] tour_len,
  output logic               perm_ok,
  output logic [5:0]         dup_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [5:0]         step_q, step_d;
  logic [63:0]        visited_q, visited_d;
  logic [COORD_W+7:0] acc_q, acc_d;
  logic               ok_q, ok_d;
  logic [5:0]         dup_q, dup_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [COORD_W+7:0] tour_len_q, tour_len_d;
  logic               perm_ok_q, perm_ok_d;
  logic [5:0]         dup_idx_q, dup_idx_d;

  logic [5:0]         city_a, city_b;
  logic [COORD_W:0]   dx, dy;
  logic [COORD_W+1:0] step_dist;
  logic [COORD_W+7:0] acc_next;
  logic               dup_found;

  // One tour edge: path[i] to path[i+1]; the 6-bit index wrap closes the tour at step 63.
  always_comb begin
    city_a    = path[step_q];
    city_b    = path[step_q + 6'd1];
    dx        = (xs[city_a] >= xs[city_b]) ? ({1'b0, xs[city_a]} - {1'b0, xs[city_b]})
                                           : ({1'b0, xs[city_b]} - {1'b0, xs[city_a]});
    dy        = (ys[city_a] >= ys[city_b]) ? ({1'b0, ys[city_a]} - {1'b0, ys[city_b]})
                                           : ({1'b0, ys[city_b]} - {1'b0, ys[city_a]});
    step_dist = {1'b0, dx} + {1'b0, dy};
    acc_next  = acc_q + {6'd0, step_dist};
    dup_found = visited_q[city_a] && ok_q;
  end

  // NOTE: every _d gets a hold/default value first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    visited_d  = visited_q;
    acc_d      = acc_q;
    ok_d       = ok_q;
    dup_d      = dup_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tour_len_d = tour_len_q;
    perm_ok_d  = perm_ok_q;
    dup_idx_d  = dup_idx_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          step_d    = 6'd0;
          visited_d = 64'd0;
          acc_d     = '0;
          ok_d      = 1'b1;
          dup_d     = 6'd0;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        acc_d     = acc_next;
        visited_d = visited_q | (64'd1 << city_a);
        if (dup_found) begin
          ok_d  = 1'b0;
          dup_d = step_q;
        end
        step_d = step_q + 6'd1;
        if (step_q == 6'd63) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          tour_len_d = acc_next;
          perm_ok_d  = ok_d;
          dup_idx_d  = dup_d;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= 6'd0;
      visited_q  <= 64'd0;
      acc_q      <= '0;
      ok_q       <= 1'b0;
      dup_q      <= 6'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tour_len_q <= '0;
      perm_ok_q  <= 1'b0;
      dup_idx_q  <= 6'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      visited_q  <= visited_d;
      acc_q      <= acc_d;
      ok_q       <= ok_d;
      dup_q      <= dup_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tour_len_q <= tour_len_d;
      perm_ok_q  <= perm_ok_d;
      dup_idx_q  <= dup_idx_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tour_len = tour_len_q;
  assign perm_ok  = perm_ok_q;
  assign dup_idx  = dup_idx_q;

endmodule

// File: tb/tb_tsp_tour_checker.sv
// Self-checking bench for tsp_tour_checker: directed corner tours plus randomized tours
// compared against a loop-based reference model.
module tb_tsp_tour_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] xs [63:0];
  logic [7:0] ys [63:0];
  logic [5:0] path [63:0];
  logic       busy, done, perm_ok;
  logic [15:0] tour_len;
  logic [5:0] dup_idx;

  int n_checks = 0;
  int n_errors = 0;

  int exp_len;
  int exp_ok;
  int exp_dup;

  tsp_tour_checker #(.COORD_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .xs(xs), .ys(ys), .path(path),
    .busy(busy), .done(done), .tour_len(tour_len),
    .perm_ok(perm_ok), .dup_idx(dup_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compute_expected();
    bit seen [64];
    int a, b, dxv, dyv;
    exp_len = 0;
    exp_ok  = 1;
    exp_dup = 0;
    for (int k = 0; k < 64; k++) seen[k] = 1'b0;
    for (int i = 0; i < 64; i++) begin
      a   = int'(path[i]);
      b   = int'(path[(i + 1) % 64]);
      dxv = int'(xs[a]) - int'(xs[b]);
      dyv = int'(ys[a]) - int'(ys[b]);
      if (dxv < 0) dxv = -dxv;
      if (dyv < 0) dyv = -dyv;
      exp_len += dxv + dyv;
      if (seen[a] && exp_ok == 1) begin
        exp_ok  = 0;
        exp_dup = i;
      end
      seen[a] = 1'b1;
    end
  endtask

  // Starts a run from IDLE, waits (bounded) for done and checks timing and results.
  task automatic run_and_check(input string tag);
    int cyc;
    int busy_cnt;
    bit got;
    compute_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    got      = 1'b0;
    while (!got && cyc <= 200) begin
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'd65);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd64);
    check({tag, "_tour_len"}, 32'(tour_len), 32'(exp_len));
    check({tag, "_perm_ok"}, 32'(perm_ok), 32'(exp_ok));
    check({tag, "_dup_idx"}, 32'(dup_idx), 32'(exp_dup));
    @(posedge clk); #1;
    check({tag, "_done_single"}, 32'(done), 32'd0);
    check({tag, "_len_hold"}, 32'(tour_len), 32'(exp_len));
  endtask

  task automatic shuffle_path();
    int j;
    logic [5:0] t;
    for (int i = 0; i < 64; i++) path[i] = 6'(i);
    for (int i = 63; i > 0; i--) begin
      j       = int'($urandom_range(0, i));
      t       = path[i];
      path[i] = path[j];
      path[j] = t;
    end
  endtask

  initial begin
    int done_cnt;
    int first_done;
    int second_done;
    int p, q;

    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      xs[i] = 8'(i); ys[i] = 8'd0; path[i] = 6'(i);
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_len", 32'(tour_len), 32'd0);
    check("reset_perm", 32'(perm_ok), 32'd0);
    check("reset_dup", 32'(dup_idx), 32'd0);
    rst = 1'b0;

    // Line tour, started in the first cycle after reset release.
    run_and_check("line");
    check("line_const_len", 32'(tour_len), 32'd126);

    for (int i = 0; i < 64; i++) begin
      xs[i] = 8'd0; ys[i] = 8'd0; path[i] = 6'(63 - i);
    end
    run_and_check("zero_rev");

    for (int i = 0; i < 64; i++) path[i] = 6'd0;
    xs[0] = 8'd5; ys[0] = 8'd5;
    run_and_check("all_zero_path");
    check("all_zero_dup_const", 32'(dup_idx), 32'd1);

    for (int i = 0; i < 64; i++) begin
      path[i] = 6'(i);
      xs[i]   = (i % 2 == 1) ? 8'd255 : 8'd0;
      ys[i]   = (i % 2 == 1) ? 8'd255 : 8'd0;
    end
    run_and_check("checker");
    check("checker_const_len", 32'(tour_len), 32'd32640);

    // Reset in the middle of a run.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_len", 32'(tour_len), 32'd0);
    check("abort_perm", 32'(perm_ok), 32'd0);
    check("abort_dup", 32'(dup_idx), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_and_check("after_abort");

    // Randomized tours: permutations, random paths, and a permutation with one forced repeat.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++) begin
        xs[i] = 8'($urandom);
        ys[i] = 8'($urandom);
      end
      if (r % 3 == 0) shuffle_path();
      else if (r % 3 == 1) begin
        for (int i = 0; i < 64; i++) path[i] = 6'($urandom_range(0, 63));
      end else begin
        shuffle_path();
        p       = int'($urandom_range(1, 63));
        q       = int'($urandom_range(0, p - 1));
        path[p] = path[q];
      end
      run_and_check($sformatf("rand%0d", r));
    end

    // Start held high: back-to-back runs.
    shuffle_path();
    compute_expected();
    done_cnt    = 0;
    first_done  = 0;
    second_done = 0;
    start = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(posedge clk); #1;
      if (c == 100) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) first_done = c;
        if (done_cnt == 2) second_done = c;
        check("held_len", 32'(tour_len), 32'(exp_len));
        check("held_perm", 32'(perm_ok), 32'(exp_ok));
      end
    end
    check("held_done_count", 32'(done_cnt), 32'd2);
    check("held_first_done", 32'(first_done), 32'd65);
    check("held_gap", 32'(second_done - first_done), 32'd66);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tsp_tour_checker.md
TSP_TOUR_CHECKER -- requirements
Module: tsp_tour_checker

Interface
REQ-001 SHALL have parameter: COORD_W, default 8, bit width of each x/y coordinate.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port: start  input  1  request to evaluate the current tour; level-sampled.
REQ-005 SHALL have port: xs  input  [COORD_W-1:0] x 64 (unpacked [63:0])  city x coordinates.
REQ-006 SHALL have port: ys  input  [COORD_W-1:0] x 64 (unpacked [63:0])  city y coordinates.
REQ-007 SHALL have port: path  input  [5:0] x 64 (unpacked [63:0])  visiting order; path[i] is the city index at step i.
REQ-008 SHALL have port: busy  output  1  high while the walk is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; results are valid from this cycle on.
REQ-010 SHALL have port: tour_len  output  COORD_W+8  closed-tour Manhattan length.
REQ-011 SHALL have port: perm_ok  output  1  path is a permutation of 0..63.
REQ-012 SHALL have port: dup_idx  output  6  lowest step i whose path[i] repeats an earlier step; 0 when perm_ok=1.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE: IDLE->RUN on start=1; RUN->DONE after step 63; DONE->IDLE unconditionally.
REQ-014 SHALL, on accepting start, clear the accumulator, the 64-bit visited mask, perm_ok internal flag (set to 1), dup_idx, and the step counter i (to 0).
REQ-015 SHALL, in RUN, process exactly one step i per cycle, i = 0..63 in order.
REQ-016 SHALL, in each step, add |xs[a]-xs[b]| + |ys[a]-ys[b]| to the accumulator, where a=path[i], b=path[(i+1) mod 64]; step 63 closes the tour back to path[0].
REQ-017 SHALL form differences at COORD_W+1 bits and the sum at COORD_W+2 bits; the accumulator (COORD_W+8 bits) cannot overflow (max 64*2*(2^COORD_W-1)).
REQ-018 SHALL, in each step, test visited[path[i]]: if already set and perm_ok is still 1, clear perm_ok and record dup_idx=i; then set visited[path[i]].
REQ-019 SHALL continue summing after a duplicate is found; tour_len is reported regardless of perm_ok.
REQ-020 SHALL hold busy=1 for exactly 64 cycles, starting the cycle after the accepting edge.
REQ-021 SHALL assert done=1 for exactly one cycle (the DONE state), 65 cycles after the accepting edge, with tour_len/perm_ok/dup_idx updated in that same cycle.
REQ-022 SHALL hold tour_len, perm_ok and dup_idx stable from done until the next accepted start.
REQ-023 SHALL ignore start in RUN and DONE; start held high continuously yields a new run every 66 cycles.
REQ-024 SHALL require xs, ys and path to be stable while busy=1; the block does not snapshot them and results with changing inputs are undefined.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, enter IDLE and drive busy=0, done=0, tour_len=0, perm_ok=0, dup_idx=0, and clear the visited mask and step counter.
REQ-026 SHALL treat rst as dominant over start in the same cycle; a run interrupted by reset produces no done pulse.
REQ-027 SHALL accept a start in the first cycle after rst deasserts.

Verification
REQ-028 SHALL pass: path[i]=i, xs[i]=i, ys[i]=0, start pulse -> done once after 65 cycles, tour_len=126, perm_ok=1, dup_idx=0.
REQ-029 SHALL pass: all coordinates 0, path[i]=63-i -> tour_len=0, perm_ok=1.
REQ-030 SHALL pass: path all 0, xs[0]=ys[0]=5 -> tour_len=0, perm_ok=0, dup_idx=1.
REQ-031 SHALL pass: path[i]=i, even cities at (0,0), odd at (255,255) -> tour_len=32640, perm_ok=1.
REQ-032 SHALL pass: rst=1 pulsed during RUN at step 30 -> busy=0, done never pulses, all outputs 0; a following start gives the full correct result.
REQ-033 SHALL pass: start held high for 100 cycles -> exactly two done pulses, 66 cycles apart, identical results.
